// File: rtl/hdmi_i2c_target_if.sv
// Bus pins and byte-wide register port of the HDMI I2C target.
interface hdmi_i2c_target_if;
  logic       I2C_SCL;
  logic       I2C_SDA_IN;
  logic       I2C_SDA_OE;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic [7:0] reg_rdata;
  logic       busy;

  modport slave  (input  I2C_SCL, I2C_SDA_IN, reg_rdata,
                  output I2C_SDA_OE, reg_addr, reg_wdata, reg_we, busy);
  modport master (output I2C_SCL, I2C_SDA_IN, reg_rdata,
                  input  I2C_SDA_OE, reg_addr, reg_wdata, reg_we, busy);
endinterface

// File: rtl/hdmi_i2c_target.sv
// Oversampling I2C register target: [addr+W][sub][data..] writes, [addr+W][sub] Sr [addr+R][data..] reads.
module hdmi_i2c_filt #(
  parameter int FILTER = 3
) (
  input  logic iCLK,
  input  logic iRST_N,
  input  logic din,
  output logic dout
);
  localparam int CW = $clog2(FILTER + 1);
  logic [1:0]    sync_pipe;
  logic [CW-1:0] cnt;

  // level is accepted only after FILTER consecutive cycles differing from the current output
  always_ff @(posedge iCLK or negedge iRST_N)
    if (!iRST_N) begin
      sync_pipe <= 2'b11;
      cnt       <= '0;
      dout      <= 1'b1;
    end else begin
      sync_pipe <= {sync_pipe[0], din};
      if (sync_pipe[1] == dout)                cnt <= '0;
      else if (cnt == CW'(FILTER - 1)) begin dout <= sync_pipe[1]; cnt <= '0; end
      else                                     cnt <= cnt + 1'b1;
    end
endmodule

module hdmi_i2c_target #(
  parameter logic [6:0] I2C_ADDR = 7'h39,
  parameter int         FILTER   = 3
) (
  input logic               iCLK,
  input logic               iRST_N,
  hdmi_i2c_target_if.slave  bus
);
  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, SUB, SUB_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT
  } st_t;

  st_t        st, st_n;
  logic [1:0] pin_raw, pin_f, pin_q;
  logic       scl_f, sda_f, scl_q, sda_q;
  logic       scl_rise, scl_fall, start, stop;
  logic [2:0] bcnt, bcnt_n;
  logic [6:0] sh, sh_n;
  logic [7:0] tx, tx_n, addr, addr_n, wdata, wdata_n, byte_in;
  logic       oe, oe_n, rw, rw_n, we, we_n, busy_r, busy_n;

  assign pin_raw = {bus.I2C_SCL, bus.I2C_SDA_IN};

  hdmi_i2c_filt #(.FILTER(FILTER)) u_filt [1:0] (
    .iCLK   (iCLK),
    .iRST_N (iRST_N),
    .din    (pin_raw),
    .dout   (pin_f)
  );

  assign scl_f    = pin_f[1];
  assign sda_f    = pin_f[0];
  assign scl_q    = pin_q[1];
  assign sda_q    = pin_q[0];
  assign scl_rise =  scl_f & ~scl_q;
  assign scl_fall = ~scl_f &  scl_q;
  assign start    =  scl_f &  scl_q &  sda_q & ~sda_f;
  assign stop     =  scl_f &  scl_q & ~sda_q &  sda_f;
  assign byte_in  = {sh, sda_f};

  assign bus.I2C_SDA_OE = oe;
  assign bus.reg_addr   = addr;
  assign bus.reg_wdata  = wdata;
  assign bus.reg_we     = we;
  assign bus.busy       = busy_r;

  always_ff @(posedge iCLK or negedge iRST_N)
    if (!iRST_N) begin
      st     <= IDLE;
      pin_q  <= 2'b11;
      bcnt   <= '0;
      sh     <= '0;
      tx     <= '0;
      addr   <= '0;
      wdata  <= '0;
      oe     <= 1'b0;
      rw     <= 1'b0;
      we     <= 1'b0;
      busy_r <= 1'b0;
    end else begin
      st     <= st_n;
      pin_q  <= pin_f;
      bcnt   <= bcnt_n;
      sh     <= sh_n;
      tx     <= tx_n;
      addr   <= addr_n;
      wdata  <= wdata_n;
      oe     <= oe_n;
      rw     <= rw_n;
      we     <= we_n;
      busy_r <= busy_n;
    end

  always_comb begin
    st_n    = st;
    bcnt_n  = bcnt;
    sh_n    = sh;
    tx_n    = tx;
    addr_n  = addr;
    wdata_n = wdata;
    oe_n    = oe;
    rw_n    = rw;
    we_n    = 1'b0;
    busy_n  = busy_r;
    if (we) addr_n = addr + 8'd1;
    if (start) begin
      st_n   = ADDR;
      bcnt_n = '0;
      oe_n   = 1'b0;
      busy_n = 1'b1;
    end else if (stop) begin
      st_n   = IDLE;
      oe_n   = 1'b0;
      busy_n = 1'b0;
    end else begin
      case (st)
        ADDR, SUB, WDATA:
          if (scl_rise) begin
            sh_n   = byte_in[6:0];
            bcnt_n = bcnt + 3'd1;
            if (bcnt == 3'd7)
              case (st)
                ADDR:
                  if (byte_in[7:1] == I2C_ADDR) begin st_n = ADDR_ACK; rw_n = byte_in[0]; end
                  else st_n = WAIT;
                SUB:     begin st_n = SUB_ACK; addr_n = byte_in; end
                default: begin st_n = WDATA_ACK; wdata_n = byte_in; we_n = 1'b1; end
              endcase
          end
        // first scl_fall pulls SDA for the ACK, second one ends the slot
        ADDR_ACK, SUB_ACK, WDATA_ACK:
          if (scl_fall) begin
            oe_n   = ~oe;
            bcnt_n = '0;
            if (oe) begin
              if (st == ADDR_ACK && rw) begin
                st_n = RDATA;
                tx_n = {bus.reg_rdata[6:0], 1'b0};
                oe_n = ~bus.reg_rdata[7];
              end else if (st == ADDR_ACK) st_n = SUB;
              else                         st_n = WDATA;
            end
          end
        RDATA:
          if (scl_rise) begin
            bcnt_n = bcnt + 3'd1;
            if (bcnt == 3'd7) st_n = RDATA_ACK;
          end else if (scl_fall) begin
            oe_n = ~tx[7];
            tx_n = {tx[6:0], 1'b0};
          end
        // bcnt sequences release -> master ACK sample -> next byte load
        RDATA_ACK:
          case (bcnt)
            3'd0: if (scl_fall) begin oe_n = 1'b0; addr_n = addr + 8'd1; bcnt_n = 3'd1; end
            3'd1: if (scl_rise) begin
                    if (sda_f) st_n = WAIT;
                    else       bcnt_n = 3'd2;
                  end
            default:
              if (scl_fall) begin
                st_n   = RDATA;
                bcnt_n = '0;
                tx_n   = {bus.reg_rdata[6:0], 1'b0};
                oe_n   = ~bus.reg_rdata[7];
              end
          endcase
        default: ;
      endcase
    end
  end
endmodule

// File: doc/hdmi_i2c_target.md
# hdmi_i2c_target

I2C target (slave) that answers the register-write protocol the HDMI configuration sequencer issues on `I2C_SCL`/`I2C_SDA`. It decodes `[addr+W][subaddr][data...]` writes and `[addr+W][subaddr] Sr [addr+R][data...]` reads, and exposes them as a simple byte-wide register port. It is used as a transmitter-chip stand-in on simulation benches and as the responder for an on-FPGA register bank behind the same bus. It is clocked by the system clock and oversamples the bus; it does not use SCL as a clock.

## Interface
- `I2C_ADDR`, default `7'h39`: 7-bit target address matched against the first byte after START.
- `FILTER`, default `3`: iCLK cycles an input level must be stable before it is accepted (glitch filter), minimum 1.
- `iCLK` in 1: system clock, at least 20× the SCL rate.
- `iRST_N` in 1: reset. Asynchronous, active-low; clock `iCLK`.
- `I2C_SCL` in 1: bus clock, raw pin level.
- `I2C_SDA_IN` in 1: bus data, raw pin level.
- `I2C_SDA_OE` out 1: 1 means pull SDA low; 0 means release. The top level builds the open-drain pad from this.
- `reg_addr` out 8: current register pointer.
- `reg_wdata` out 8: received data byte, valid while `reg_we` is high.
- `reg_we` out 1: one-cycle write strobe.
- `reg_rdata` in 8: register contents at `reg_addr`. May be combinational.
- `busy` out 1: high from any START until STOP.

## Operation
- **Input conditioning**
  - SCL and SDA each pass a 2-flop synchronizer, then the FILTER stability counter.
  - Edges are detected on the filtered levels: `scl_rise`, `scl_fall`, `start` (SDA falls while SCL is high), `stop` (SDA rises while SCL is high).
- **State machine**: IDLE, ADDR, ADDR_ACK, SUB, SUB_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT.
  - Shift register captures SDA MSB-first on `scl_rise`. A 3-bit bit counter is reset at START and at each ACK slot.
  - **START from any state**: go to ADDR and clear the bit counter. `reg_addr` is kept, which makes repeated-start reads work.
  - **STOP from any state**: go to IDLE and release SDA.
  - **ADDR, after 8 bits**:
    - Upper 7 bits equal `I2C_ADDR`: go to ADDR_ACK.
    - Otherwise: go to WAIT, with no ACK and SDA released until the next START or STOP.
- **ACK drive**: `I2C_SDA_OE` asserts on the `scl_fall` after bit 8 and releases on the `scl_fall` after bit 9.
  - After ADDR_ACK, the R/W bit selects the next state: 0 goes to SUB, 1 goes to RDATA.
  - After SUB_ACK, go to WDATA.
  - After WDATA_ACK, go to WDATA.
- **SUB**: after the byte, load `reg_addr` and ACK.
- **WDATA**: after the byte, on its 8th `scl_rise`:
  - Drive `reg_wdata` with the byte and pulse `reg_we` for 1 cycle.
  - Next cycle, increment `reg_addr` mod 256 (0xFF wraps to 0x00).
  - ACK the byte.
- **RDATA**
  - On the `scl_fall` that ends the address ACK or the previous read ACK, latch `reg_rdata` into the transmit shifter.
  - Drive each bit on `scl_fall`: `I2C_SDA_OE = ~bit`.
  - After 8 bits, release SDA, increment `reg_addr`, and sample the master's ACK on the 9th `scl_rise`.
    - Master ACK (SDA low): go to RDATA.
    - Master NACK: go to WAIT.
- **Reset**
  - `I2C_SDA_OE`=0, `reg_we`=0, `reg_wdata`=0x00, `reg_addr`=0x00, `busy`=0; state IDLE.
  - Asserting reset mid-transfer releases SDA asynchronously.
- **Simultaneous events**:
  - START or STOP takes priority over any bit edge in the same cycle.
  - A START/STOP during a byte aborts it. No `reg_we` is issued for a partial byte.

## Timing
- Pin-to-filtered-edge latency is 2 + FILTER iCLK cycles, applied equally to SCL and SDA.
- `reg_we` fires 1 cycle after the filtered 8th `scl_rise` of a data byte. `reg_addr` updates the cycle after `reg_we`.
- SDA drive changes 1 cycle after the filtered `scl_fall`, i.e. 3 + FILTER cycles after the pin. This is well inside SCL low at 20 kHz SCL on 50 MHz.
- `reg_rdata` is sampled exactly once per read byte, at the latch point above. Changes after that point do not affect the byte in flight.
- `busy` rises 1 cycle after the filtered START and falls 1 cycle after the filtered STOP.

## Test plan
- **Single write**: START, 0x72, 0x98, 0x03, STOP → ACK on all 3 bytes; exactly one `reg_we` with `reg_wdata`=0x03 and `reg_addr`=0x98; `reg_addr`=0x99 afterwards; `busy` back to 0.
- **Burst write with wrap**: START, 0x72, 0xFF, 0x11, 0x22, STOP → two writes, FF←0x11 then 00←0x22; final `reg_addr`=0x01.
- **Address mismatch**: START, 0x50, 0xAA, STOP → `I2C_SDA_OE` never asserted; no `reg_we`; `reg_addr` unchanged.
- **Combined read**: START, 0x72, 0x41, Sr, 0x73, then read 2 bytes with master ACK then NACK, then STOP; `reg_rdata` model returns addr^0x5A → bytes 0x1B, 0x18 are seen on SDA; no `reg_we`; final `reg_addr`=0x43.
- **Glitch rejection**: 1-cycle SCL high pulse and 2-cycle SDA dip inserted during a write, with FILTER=3 → transfer completes identically to the single-write case.
- **Reset during ACK**: assert `iRST_N` low while `I2C_SDA_OE`=1 → `I2C_SDA_OE` goes to 0 with no clock edge; after release, a new single write succeeds.
